// File: rtl/arbiter_4ch.sv
// Four-requester arbiter: fixed-priority or round-robin selection, bounded grant
// tenure with a timeout pulse, and a one-cycle idle gap between grants.
module arbiter_4ch #(
    parameter int RR_MODE  = 1,
    parameter int MAX_HOLD = 15
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       E,
    input  logic [3:0] I,
    input  logic       done,
    output logic [3:0] G,
    output logic [1:0] Y,
    output logic       V,
    output logic       timeout
);

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } state_e;

    localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 32'sd1);
    localparam bit         USE_RR    = (RR_MODE != 32'sd0);

    state_e     state_q,   state_d;
    logic [3:0] g_q,       g_d;
    logic [1:0] y_q,       y_d;
    logic       v_q,       v_d;
    logic       timeout_q, timeout_d;
    logic [1:0] ptr_q,     ptr_d;
    logic [7:0] hold_q,    hold_d;

    logic [1:0] win_s;
    logic       owner_req_s;
    logic       expire_s;
    logic       release_s;

    function automatic logic [1:0] lowest_set(input logic [3:0] req);
        logic [1:0] idx;
        casez (req)
            4'b???1: idx = 2'd0;
            4'b??10: idx = 2'd1;
            4'b?100: idx = 2'd2;
            4'b1000: idx = 2'd3;
            default: idx = 2'd0;
        endcase
        return idx;
    endfunction

    function automatic logic [1:0] highest_set(input logic [3:0] req);
        logic [1:0] idx;
        casez (req)
            4'b1???: idx = 2'd3;
            4'b01??: idx = 2'd2;
            4'b001?: idx = 2'd1;
            default: idx = 2'd0;
        endcase
        return idx;
    endfunction

    // Rotate so the pointer lands on bit 0, find the first request, then undo the rotation.
    function automatic logic [1:0] pick_rr(input logic [3:0] req, input logic [1:0] ptr);
        logic [7:0] dbl;
        dbl = {req, req} >> ptr;
        return lowest_set(dbl[3:0]) + ptr;
    endfunction

    assign win_s       = USE_RR ? pick_rr(I, ptr_q) : highest_set(I);
    assign owner_req_s = I[y_q];
    assign expire_s    = (hold_q == HOLD_LAST);
    assign release_s   = done | ~owner_req_s | ~E | expire_s;

    // Next-state and registered-output computation for the IDLE/GRANT machine.
    always_comb begin
        state_d   = state_q;
        g_d       = g_q;
        y_d       = y_q;
        v_d       = v_q;
        timeout_d = 1'b0;
        ptr_d     = ptr_q;
        hold_d    = hold_q;
        case (state_q)
            ST_IDLE: begin
                if (E && (I != 4'b0000)) begin
                    state_d = ST_GRANT;
                    g_d     = 4'b0001 << win_s;
                    y_d     = win_s;
                    v_d     = 1'b1;
                    hold_d  = 8'd0;
                end else begin
                    g_d    = 4'b0000;
                    y_d    = 2'd0;
                    v_d    = 1'b0;
                    hold_d = 8'd0;
                end
            end
            ST_GRANT: begin
                if (release_s) begin
                    state_d   = ST_IDLE;
                    g_d       = 4'b0000;
                    y_d       = 2'd0;
                    v_d       = 1'b0;
                    ptr_d     = y_q + 2'd1;
                    hold_d    = 8'd0;
                    // Only a pure expiry counts as a timeout; any voluntary release masks it.
                    timeout_d = expire_s & ~done & owner_req_s & E;
                end else begin
                    hold_d = hold_q + 8'd1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                g_d     = 4'b0000;
                y_d     = 2'd0;
                v_d     = 1'b0;
                hold_d  = 8'd0;
            end
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            g_q       <= 4'b0000;
            y_q       <= 2'd0;
            v_q       <= 1'b0;
            timeout_q <= 1'b0;
            ptr_q     <= 2'd0;
            hold_q    <= 8'd0;
        end else begin
            state_q   <= state_d;
            g_q       <= g_d;
            y_q       <= y_d;
            v_q       <= v_d;
            timeout_q <= timeout_d;
            ptr_q     <= ptr_d;
            hold_q    <= hold_d;
        end
    end

    assign G       = g_q;
    assign Y       = y_q;
    assign V       = v_q;
    assign timeout = timeout_q;

endmodule

// File: tb/tb_arbiter_4ch.sv
// Scoreboard bench for arbiter_4ch: three configurations (fixed/15, RR/3, RR/1),
// directed per-cycle vectors push expected outputs; a monitor pops and compares.
module tb_arbiter_4ch;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic       e_i    [3];
    logic [3:0] req_i  [3];
    logic       done_i [3];
    logic [3:0] g_o    [3];
    logic [1:0] y_o    [3];
    logic       v_o    [3];
    logic       to_o   [3];

    arbiter_4ch #(.RR_MODE(0), .MAX_HOLD(15)) u_fp (
        .clk(clk), .rst(rst), .E(e_i[0]), .I(req_i[0]), .done(done_i[0]),
        .G(g_o[0]), .Y(y_o[0]), .V(v_o[0]), .timeout(to_o[0]));

    arbiter_4ch #(.RR_MODE(1), .MAX_HOLD(3)) u_rr3 (
        .clk(clk), .rst(rst), .E(e_i[1]), .I(req_i[1]), .done(done_i[1]),
        .G(g_o[1]), .Y(y_o[1]), .V(v_o[1]), .timeout(to_o[1]));

    arbiter_4ch #(.RR_MODE(1), .MAX_HOLD(1)) u_rr1 (
        .clk(clk), .rst(rst), .E(e_i[2]), .I(req_i[2]), .done(done_i[2]),
        .G(g_o[2]), .Y(y_o[2]), .V(v_o[2]), .timeout(to_o[2]));

    typedef struct {
        string       tag;
        logic [11:0] g;
        logic [2:0]  t;
    } exp_t;

    exp_t exp_q[$];
    int   errors = 0;
    int   checks = 0;

    function automatic logic [1:0] idx_of(input logic [3:0] g);
        case (g)
            4'b0010: return 2'd1;
            4'b0100: return 2'd2;
            4'b1000: return 2'd3;
            default: return 2'd0;
        endcase
    endfunction

    // Drive one cycle of inputs on DUT k (others idle) and queue the outputs expected after the next edge.
    task automatic step(input int k, input logic e, input logic [3:0] req, input logic d,
                        input logic r, input logic [3:0] eg, input logic et, input string tag);
        exp_t x;
        rst = r;
        for (int j = 0; j < 3; j++) begin
            e_i[j]    = (j == k) ? e   : 1'b0;
            req_i[j]  = (j == k) ? req : 4'b0000;
            done_i[j] = (j == k) ? d   : 1'b0;
        end
        x.tag = tag;
        x.g   = 12'd0;
        x.t   = 3'd0;
        x.g[k*4 +: 4] = eg;
        x.t[k]        = et;
        exp_q.push_back(x);
        @(negedge clk);
    endtask

    // Monitor: after every rising edge, pop one expectation and compare all three DUTs.
    initial begin
        exp_t       x;
        logic [3:0] eg;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                x = exp_q.pop_front();
                for (int k = 0; k < 3; k++) begin
                    eg = x.g[k*4 +: 4];
                    checks++;
                    if ({g_o[k], y_o[k], v_o[k], to_o[k]} !== {eg, idx_of(eg), |eg, x.t[k]}) begin
                        errors++;
                        $display("FAIL %s dut%0d: got G=%b Y=%0d V=%b timeout=%b, expected G=%b Y=%0d V=%b timeout=%b",
                                 x.tag, k, g_o[k], y_o[k], v_o[k], to_o[k], eg, idx_of(eg), |eg, x.t[k]);
                    end
                end
            end
        end
    end

    initial begin
        rst = 1'b1;
        for (int j = 0; j < 3; j++) begin
            e_i[j] = 1'b0; req_i[j] = 4'b0000; done_i[j] = 1'b0;
        end
        //   k  E     I        done  rst   exp G    to    tag
        step(0, 1'b0, 4'b0000, 1'b0, 1'b1, 4'b0000, 1'b0, "reset0");
        step(0, 1'b1, 4'b1111, 1'b1, 1'b1, 4'b0000, 1'b0, "reset1");
        // Fixed priority
        step(0, 1'b1, 4'b0110, 1'b0, 1'b0, 4'b0100, 1'b0, "fp_grant");
        step(0, 1'b1, 4'b0110, 1'b0, 1'b0, 4'b0100, 1'b0, "fp_hold");
        step(0, 1'b1, 4'b1110, 1'b0, 1'b0, 4'b0100, 1'b0, "fp_no_preempt");
        step(0, 1'b1, 4'b0110, 1'b1, 1'b0, 4'b0000, 1'b0, "fp_done");
        step(0, 1'b1, 4'b0110, 1'b0, 1'b0, 4'b0100, 1'b0, "fp_regrant");
        step(0, 1'b1, 4'b0110, 1'b1, 1'b0, 4'b0000, 1'b0, "fp_done2");
        step(0, 1'b1, 4'b1011, 1'b0, 1'b0, 4'b1000, 1'b0, "fp_highest");
        step(0, 1'b0, 4'b1011, 1'b0, 1'b0, 4'b0000, 1'b0, "fp_e_drop");
        step(0, 1'b0, 4'b1111, 1'b0, 1'b0, 4'b0000, 1'b0, "fp_e0_a");
        step(0, 1'b0, 4'b1111, 1'b0, 1'b0, 4'b0000, 1'b0, "fp_e0_b");
        step(0, 1'b1, 4'b0000, 1'b1, 1'b0, 4'b0000, 1'b0, "fp_done_idle");
        step(0, 1'b1, 4'b0001, 1'b0, 1'b0, 4'b0001, 1'b0, "fp_lowest");
        step(0, 1'b1, 4'b0000, 1'b0, 1'b0, 4'b0000, 1'b0, "fp_req_drop");
        // Round-robin rotation, MAX_HOLD=3
        step(1, 1'b1, 4'b1111, 1'b0, 1'b0, 4'b0001, 1'b0, "rr_own0");
        step(1, 1'b1, 4'b1111, 1'b1, 1'b0, 4'b0000, 1'b0, "rr_gap0");
        step(1, 1'b1, 4'b1111, 1'b0, 1'b0, 4'b0010, 1'b0, "rr_own1");
        step(1, 1'b1, 4'b1111, 1'b1, 1'b0, 4'b0000, 1'b0, "rr_gap1");
        step(1, 1'b1, 4'b1111, 1'b0, 1'b0, 4'b0100, 1'b0, "rr_own2");
        step(1, 1'b1, 4'b1111, 1'b1, 1'b0, 4'b0000, 1'b0, "rr_gap2");
        step(1, 1'b1, 4'b1111, 1'b0, 1'b0, 4'b1000, 1'b0, "rr_own3");
        step(1, 1'b1, 4'b1111, 1'b1, 1'b0, 4'b0000, 1'b0, "rr_gap3");
        step(1, 1'b1, 4'b1111, 1'b0, 1'b0, 4'b0001, 1'b0, "rr_wrap0");
        step(1, 1'b1, 4'b1111, 1'b1, 1'b0, 4'b0000, 1'b0, "rr_gap4");
        // Timeout
        step(1, 1'b1, 4'b0001, 1'b0, 1'b0, 4'b0001, 1'b0, "to_c1");
        step(1, 1'b1, 4'b0001, 1'b0, 1'b0, 4'b0001, 1'b0, "to_c2");
        step(1, 1'b1, 4'b0001, 1'b0, 1'b0, 4'b0001, 1'b0, "to_c3");
        step(1, 1'b1, 4'b0001, 1'b0, 1'b0, 4'b0000, 1'b1, "to_pulse");
        step(1, 1'b1, 4'b0001, 1'b0, 1'b0, 4'b0001, 1'b0, "to_regrant");
        step(1, 1'b1, 4'b0001, 1'b0, 1'b0, 4'b0001, 1'b0, "co_c2");
        step(1, 1'b1, 4'b0001, 1'b0, 1'b0, 4'b0001, 1'b0, "co_c3");
        step(1, 1'b1, 4'b0001, 1'b1, 1'b0, 4'b0000, 1'b0, "co_done_expiry");
        step(1, 1'b1, 4'b0000, 1'b0, 1'b0, 4'b0000, 1'b0, "rr_idle");
        // Owner drop sets pointer past owner 2
        step(1, 1'b1, 4'b0100, 1'b0, 1'b0, 4'b0100, 1'b0, "drop_grant2");
        step(1, 1'b1, 4'b0000, 1'b0, 1'b0, 4'b0000, 1'b0, "drop_release");
        step(1, 1'b1, 4'b1111, 1'b0, 1'b0, 4'b1000, 1'b0, "drop_ptr3");
        // Reset mid-grant, then requester 0 first
        step(1, 1'b1, 4'b1111, 1'b0, 1'b1, 4'b0000, 1'b0, "rst_mid_grant");
        step(1, 1'b1, 4'b1111, 1'b0, 1'b0, 4'b0001, 1'b0, "rst_first0");
        step(1, 1'b1, 4'b1111, 1'b0, 1'b0, 4'b0001, 1'b0, "e_co_c2");
        step(1, 1'b1, 4'b1111, 1'b0, 1'b0, 4'b0001, 1'b0, "e_co_c3");
        step(1, 1'b0, 4'b1111, 1'b0, 1'b0, 4'b0000, 1'b0, "e_drop_expiry");
        step(1, 1'b0, 4'b1111, 1'b0, 1'b0, 4'b0000, 1'b0, "e0_hold");
        // Timeout advances the pointer
        step(1, 1'b1, 4'b1111, 1'b0, 1'b0, 4'b0010, 1'b0, "to2_c1");
        step(1, 1'b1, 4'b1111, 1'b0, 1'b0, 4'b0010, 1'b0, "to2_c2");
        step(1, 1'b1, 4'b1111, 1'b0, 1'b0, 4'b0010, 1'b0, "to2_c3");
        step(1, 1'b1, 4'b1111, 1'b0, 1'b0, 4'b0000, 1'b1, "to2_pulse");
        step(1, 1'b1, 4'b1111, 1'b0, 1'b0, 4'b0100, 1'b0, "to2_next");
        step(1, 1'b1, 4'b0000, 1'b0, 1'b0, 4'b0000, 1'b0, "rr_end");
        // MAX_HOLD=1: single-cycle grants
        step(2, 1'b1, 4'b0011, 1'b0, 1'b0, 4'b0001, 1'b0, "mh1_own0");
        step(2, 1'b1, 4'b0011, 1'b0, 1'b0, 4'b0000, 1'b1, "mh1_timeout");
        step(2, 1'b1, 4'b0011, 1'b0, 1'b0, 4'b0010, 1'b0, "mh1_own1");
        step(2, 1'b1, 4'b0011, 1'b1, 1'b0, 4'b0000, 1'b0, "mh1_done_expiry");
        step(2, 1'b1, 4'b0011, 1'b0, 1'b0, 4'b0001, 1'b0, "mh1_wrap0");
        step(2, 1'b1, 4'b0000, 1'b0, 1'b0, 4'b0000, 1'b0, "mh1_drop");
        step(2, 1'b0, 4'b0000, 1'b0, 1'b0, 4'b0000, 1'b0, "mh1_idle");

        repeat (3) @(negedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d expectations left, expected 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/arbiter_4ch.md
ARBITER_4CH -- requirements
Module: arbiter_4ch

Interface
REQ-001 Parameter: RR_MODE, default 1, 1 = round-robin arbitration, 0 = fixed priority (I[3] highest, I[0] lowest).
REQ-002 Parameter: MAX_HOLD, default 15, maximum grant tenure in cycles; legal range 1..255.
REQ-003 Port: clk  input  1  single clock; all state updates on the rising edge.
REQ-004 Port: rst  input  1  synchronous, active-high reset.
REQ-005 Port: E  input  1  arbiter enable.
REQ-006 Port: I  input  4  request vector, one bit per requester.
REQ-007 Port: done  input  1  current owner releases the resource; ignored unless state is GRANT.
REQ-008 Port: G  output  4  one-hot grant vector, registered.
REQ-009 Port: Y  output  2  encoded index of the current owner, registered; 0 when V=0.
REQ-010 Port: V  output  1  grant valid, registered; equals |G.
REQ-011 Port: timeout  output  1  one-cycle pulse on forced release by MAX_HOLD expiry.

Function
REQ-012 The block SHALL implement two states: IDLE (no owner) and GRANT (one owner).
REQ-013 In IDLE with E=1 and I!=0 at edge N, the block SHALL enter GRANT and drive G/Y/V for the winner from edge N (visible in cycle N+1); latency request-to-grant is 1 cycle.
REQ-014 In IDLE with E=0 or I=0, the block SHALL remain in IDLE with G=0, Y=0, V=0.
REQ-015 With RR_MODE=0, the winner SHALL be the highest set index of I.
REQ-016 With RR_MODE=1, the winner SHALL be the first set bit of I searching ascending from pointer P, wrapping 3->0.
REQ-017 P (2 bits) SHALL update only on release, to (owner index + 1) mod 4; P is unused when RR_MODE=0.
REQ-018 In GRANT, G/Y/V SHALL hold constant; changes on I for other requesters SHALL NOT affect the grant.
REQ-019 A hold counter (8 bits) SHALL clear on entry to GRANT and increment every cycle in GRANT.
REQ-020 Release SHALL occur at the edge where, in GRANT, any of the following holds: done=1; the owner's I bit = 0; E=0; the hold counter = MAX_HOLD-1.
REQ-021 On release, the block SHALL return to IDLE with G=0, Y=0, V=0 in the following cycle; a new grant is possible at the earliest one cycle after that (mandatory one-cycle idle gap).
REQ-022 timeout SHALL pulse for exactly one cycle, coincident with the first V=0 cycle, only when release was caused solely by counter expiry; if done, the owner's I drop or E=0 coincides with expiry, timeout SHALL stay 0.
REQ-023 With MAX_HOLD=1, every grant SHALL last exactly one cycle.
REQ-024 G SHALL never have more than one bit set; Y SHALL always equal the index of the set bit of G.
REQ-025 done asserted in IDLE SHALL have no effect.

Reset
REQ-026 rst=1 at a clock edge SHALL force state IDLE, G=0, Y=0, V=0, timeout=0, P=0, hold counter=0, overriding all other inputs including mid-grant.
REQ-027 The first grant after reset SHALL follow normal IDLE rules, with no extra delay beyond REQ-013.

Verification
REQ-028 Fixed priority (RR_MODE=0): E=1, I=4'b0110 -> next cycle G=0100, Y=2, V=1; done pulse -> V=0 for 1 cycle, then G=0100 again while I is unchanged.
REQ-029 Round-robin (RR_MODE=1): I=4'b1111 held, done pulsed each grant -> owner sequence 0,1,2,3,0 with one idle cycle between grants.
REQ-030 Timeout (MAX_HOLD=3): single request I=0001, no done -> V=1 for exactly 3 cycles, then V=0 with timeout=1 for 1 cycle, then regrant to requester 0.
REQ-031 Request drop: owner 2 clears I[2] mid-grant -> V=0 next cycle, timeout=0, and P=3.
REQ-032 Enable and reset: E=0 with I=1111 -> V stays 0; rst asserted during GRANT -> next cycle G=0, V=0, P=0, with requester 0 first in round-robin mode.
REQ-033 Coincidence: done=1 on the expiry cycle -> release with timeout=0.
